// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: opcodes and controller state encoding shared by the multicycle controller.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        kLDR = 3'b000,
        kCLR = 3'b001,
        kACC = 3'b010,
        kACI = 3'b011,
        kBZR = 3'b100,
        kBZA = 3'b101,
        kSTR = 3'b110,
        kHLT = 3'b111
    } op_mne;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } ctrl_state_t;

    function automatic logic isAluOp(input op_mne op);
        return op inside {kCLR, kACC, kACI};
    endfunction

endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter register; load wins over increment, arithmetic wraps modulo 2^PC_W.
module pc_reg #(
    parameter int PC_W = 8
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            inc,
    input  logic            load,
    input  logic [PC_W-1:0] load_val,
    output logic [PC_W-1:0] pc
);

    always_ff @(posedge CLK)
        if (reset) pc <= '0;
        else if (load) pc <= load_val;
        else if (inc) pc <= pc + 1'b1;

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/execute/memory/writeback sequencer for the accumulator datapath.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 9
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               start,
    input  logic [INSTR_W-1:0] instr,
    input  logic               zero,
    input  logic               mem_ready,
    output logic [PC_W-1:0]    pc,
    output op_mne              alu_op,
    output logic               alu_en,
    output logic               reg_we,
    output logic [5:0]         reg_addr,
    output logic               mem_req,
    output logic               mem_we,
    output logic               busy,
    output logic               done
);

    ctrl_state_t        state, nextState;
    logic [INSTR_W-1:0] ir;
    op_mne              irOp;
    logic [5:0]         irOpnd;
    logic               pcInc, pcLoad;
    logic [PC_W-1:0]    pcLoadVal;

    assign irOp   = op_mne'(ir[INSTR_W-1 -: 3]);
    assign irOpnd = ir[5:0];

    pc_reg #(.PC_W(PC_W)) u_pc (
        .CLK     (CLK),
        .reset   (reset),
        .inc     (pcInc),
        .load    (pcLoad),
        .load_val(pcLoadVal),
        .pc      (pc)
    );

    always_ff @(posedge CLK)
        if (reset) begin
            state <= IDLE;
            ir    <= '0;
        end else begin
            state <= nextState;
            if (state == FETCH) ir <= instr;
        end

    // zero and mem_ready only steer the next state and pc, never an output directly
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = start ? FETCH : IDLE;
            FETCH:   nextState = DECODE;
            DECODE:  nextState = (irOp == kHLT) ? HALT : (irOp inside {kLDR, kSTR}) ? MEM : EXEC;
            EXEC:    nextState = isAluOp(irOp) ? WB : FETCH;
            MEM:     nextState = !mem_ready ? MEM : (irOp == kLDR) ? WB : FETCH;
            WB:      nextState = FETCH;
            default: nextState = HALT;
        endcase
        pcLoad    = (state == IDLE && start) || (state == EXEC && zero && irOp inside {kBZR, kBZA});
        pcLoadVal = (state == IDLE) ? '0 :
                    (irOp == kBZR)  ? pc + PC_W'($signed(irOpnd)) : PC_W'(irOpnd);
        pcInc     = (state == WB) || (state == EXEC && irOp inside {kBZR, kBZA}) ||
                    (state == MEM && mem_ready && irOp == kSTR);
    end

    always_comb begin
        alu_op   = irOp;
        alu_en   = state == EXEC && isAluOp(irOp);
        reg_we   = state == WB;
        reg_addr = irOpnd;
        mem_req  = state == MEM;
        mem_we   = state == MEM && irOp == kSTR;
        busy     = !(state inside {IDLE, HALT});
        done     = state == HALT;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: instruction-level reference model drives randomized programs and checks every cycle.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    logic       CLK = 1'b0;
    logic       reset = 1'b1, start = 1'b0, zero = 1'b0, mem_ready = 1'b0;
    logic [8:0] instr;
    logic [7:0] pc;
    logic [2:0] aluOp;
    logic       alu_en, reg_we, mem_req, mem_we, busy, done;
    logic [5:0] regAddr;

    logic [8:0] rom [256];
    logic [7:0] mPc;
    bit         zPlan[$];
    int         waitPlan[$];
    string      phase;
    int         vecs = 0, errs = 0;

    assign instr = rom[pc];

    always #5 CLK = ~CLK;

    multicycle_ctrl #(.PC_W(8), .INSTR_W(9)) dut (
        .CLK      (CLK),
        .reset    (reset),
        .start    (start),
        .instr    (instr),
        .zero     (zero),
        .mem_ready(mem_ready),
        .pc       (pc),
        .alu_op   (aluOp),
        .alu_en   (alu_en),
        .reg_we   (reg_we),
        .reg_addr (regAddr),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .busy     (busy),
        .done     (done)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s %s: got %0h, expected %0h (t=%0t)", phase, tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] mk(input logic [2:0] op, input logic [5:0] opd);
        return {op, opd};
    endfunction

    // Called at a falling edge: check outputs, drive this cycle's inputs, move to the next falling edge.
    // ctl = {busy, done, alu_en, reg_we, mem_req, mem_we}
    task automatic cyc(input logic [5:0] ctl, input logic [7:0] ePc, input bit chkIr,
                       input logic [2:0] eOp, input logic [5:0] eOpnd,
                       input logic st, input logic z, input logic mr, input logic rs);
        checkEq("ctl", {26'd0, busy, done, alu_en, reg_we, mem_req, mem_we}, {26'd0, ctl});
        checkEq("pc", {24'd0, pc}, {24'd0, ePc});
        if (chkIr) begin
            checkEq("alu_op", {29'd0, aluOp}, {29'd0, eOp});
            checkEq("reg_addr", {26'd0, regAddr}, {26'd0, eOpnd});
        end
        start = st;
        zero = z;
        mem_ready = mr;
        reset = rs;
        @(negedge CLK);
    endtask

    task automatic doReset();
        @(negedge CLK);
        reset = 1'b1;
        start = 1'($urandom % 2);
        mem_ready = 1'($urandom % 2);
        repeat (2) @(negedge CLK);
    endtask

    // Cycle template per instruction class: ALU 4, branch 3, STR 3+wait, LDR 4+wait, HLT stops after decode.
    task automatic runInstr(input int abortCyc, output bit halted, output bit aborted);
        logic [8:0] w;
        logic [2:0] op;
        logic [5:0] opd;
        logic [5:0] ctlQ[$];
        bit         z, isMem, isStr, mr, zd;
        int         wt, off;
        w = rom[mPc];
        op = w[8:6];
        opd = w[5:0];
        z = (zPlan.size() > 0) ? zPlan.pop_front() : 1'($urandom % 2);
        wt = (waitPlan.size() > 0) ? waitPlan.pop_front() : int'($urandom_range(0, 3));
        halted = 1'b0;
        aborted = 1'b0;
        isMem = (op == kLDR) || (op == kSTR);
        isStr = op == kSTR;
        ctlQ.push_back(6'b100000);
        ctlQ.push_back(6'b100000);
        if (op inside {kCLR, kACC, kACI}) begin
            ctlQ.push_back(6'b101000);
            ctlQ.push_back(6'b100100);
        end else if (op inside {kBZR, kBZA}) begin
            ctlQ.push_back(6'b100000);
        end else if (isMem) begin
            repeat (wt + 1) ctlQ.push_back({5'b10001, isStr});
            if (!isStr) ctlQ.push_back(6'b100100);
        end
        for (int k = 0; k < ctlQ.size(); k++) begin
            mr = (isMem && k >= 2 && k <= 2 + wt) ? (k == 2 + wt) : 1'($urandom % 2);
            zd = (k == 2) ? z : 1'($urandom % 2);
            cyc(ctlQ[k], mPc, k > 0, op, opd, 1'($urandom % 4 == 0), zd, mr, k == abortCyc);
            if (k == abortCyc) begin
                aborted = 1'b1;
                return;
            end
        end
        if (op == kHLT) begin
            halted = 1'b1;
            return;
        end
        off = opd[5] ? int'(opd) - 64 : int'(opd);
        if (op == kBZR && z) mPc = 8'((int'(mPc) + off) % 256);
        else if (op == kBZA && z) mPc = {2'b00, opd};
        else mPc = 8'((int'(mPc) + 1) % 256);
    endtask

    task automatic episode(input string nm, input int maxI, input int abortI, input int abortC);
        bit h, ab;
        logic [8:0] w;
        phase = nm;
        doReset();
        cyc(6'b000000, 8'd0, 1'b1, 3'd0, 6'd0, 1'b1, 1'($urandom % 2), 1'($urandom % 2), 1'b0);
        mPc = 8'd0;
        for (int i = 0; i < maxI; i++) begin
            runInstr((i == abortI) ? abortC : -1, h, ab);
            if (ab) begin
                cyc(6'b000000, 8'd0, 1'b1, 3'd0, 6'd0, 1'b1, 1'($urandom % 2), 1'($urandom % 2), 1'b0);
                mPc = 8'd0;
            end else if (h) begin
                w = rom[mPc];
                repeat (3)
                    cyc(6'b010000, mPc, 1'b1, kHLT, w[5:0], 1'($urandom % 2),
                        1'($urandom % 2), 1'($urandom % 2), 1'b0);
                break;
            end
        end
        zPlan.delete();
        waitPlan.delete();
    endtask

    task automatic clearRom();
        foreach (rom[i]) rom[i] = 9'd0;
    endtask

    initial begin
        logic [2:0] op;
        clearRom();
        rom[0] = mk(kCLR, 6'd1);
        rom[1] = mk(kACC, 6'd1);
        rom[2] = mk(kHLT, 6'd0);
        episode("clr_acc_hlt", 10, -1, 0);

        clearRom();
        rom[0] = mk(kLDR, 6'd3);
        rom[1] = mk(kHLT, 6'd0);
        waitPlan.push_back(3);
        episode("ldr_wait3", 5, -1, 0);

        clearRom();
        rom[0] = mk(kBZA, 6'd5);
        rom[5] = mk(kBZR, 6'b111110);
        rom[3] = mk(kHLT, 6'd0);
        rom[6] = mk(kHLT, 6'd1);
        zPlan = '{1'b1, 1'b1};
        episode("bzr_taken", 5, -1, 0);
        zPlan = '{1'b1, 1'b0};
        episode("bzr_not_taken", 5, -1, 0);

        clearRom();
        rom[0] = mk(kBZR, 6'b111111);
        rom[255] = mk(kBZA, 6'd40);
        rom[40] = mk(kHLT, 6'd0);
        zPlan = '{1'b1, 1'b0, 1'b0};
        episode("bza_wrap", 3, -1, 0);
        zPlan = '{1'b1, 1'b1};
        episode("bza_taken", 5, -1, 0);

        clearRom();
        rom[0] = mk(kSTR, 6'd2);
        rom[1] = mk(kHLT, 6'd0);
        waitPlan = '{5, 1};
        episode("str_reset", 5, 0, 3);

        for (int e = 0; e < 30; e++) begin
            foreach (rom[i]) begin
                op = 3'($urandom_range(0, 7));
                if (op == kHLT && $urandom % 4 != 0) op = 3'($urandom_range(0, 6));
                rom[i] = mk(op, 6'($urandom));
            end
            episode($sformatf("rand%0d", e), 30,
                    ($urandom % 3 == 0) ? int'($urandom_range(0, 10)) : -1,
                    int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
